// File: rtl/sub_result_fifo.sv
// Output buffer for the 32-bit subtractor: a small synchronous FIFO of {over_flow, result}
// entries with valid/ready on both sides, plus a sticky overflow flag and a saturating overflow counter.
module sub_result_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_result,
   input  logic                     in_over_flow,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_result,
   output logic                     out_over_flow,
   input  logic                     out_ready,
   input  logic                     clr_sticky,
   output logic                     sticky_ovf,
   output logic [7:0]               ovf_cnt,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // in_ready and out_valid come from registered pointers only, never from in_valid/out_ready.
   logic [WIDTH:0] mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic           sticky_q, sticky_d;
   logic [7:0]     cnt_q, cnt_d;

   logic empty, full, push, pop, ovf_push;
   logic [WIDTH:0] head;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign push     = in_valid & ~full;
   assign pop      = out_ready & ~empty;
   assign ovf_push = push & in_over_flow;
   assign level    = wr_ptr_q - rd_ptr_q;

   assign head          = mem_q[rd_ptr_q[AW-1:0]];
   assign out_result    = empty ? '0 : head[WIDTH-1:0];
   assign out_over_flow = empty ? 1'b0 : head[WIDTH];

   assign sticky_ovf = sticky_q;
   assign ovf_cnt    = cnt_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      // An overflow push outranks a same-cycle clear: the clear wipes history, the push counts as one.
      if (ovf_push) begin
         sticky_d = 1'b1;
         if (clr_sticky)          cnt_d = 8'd1;
         else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end else if (clr_sticky) begin
         sticky_d = 1'b0;
         cnt_d    = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= 8'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; empty pointers gate the outputs to zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_over_flow, in_result};
   end

endmodule

// File: tb/tb_sub_result_fifo.sv
// Directed bench for sub_result_fifo: reset, fill/drain, full-rate wrap, overflow flag and counter.
module tb_sub_result_fifo;

   logic        clk;
   logic        n_rst;
   logic        in_valid;
   logic [31:0] in_result;
   logic        in_over_flow;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_result;
   logic        out_over_flow;
   logic        out_ready;
   logic        clr_sticky;
   logic        sticky_ovf;
   logic [7:0]  ovf_cnt;
   logic [2:0]  level;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   sub_result_fifo #(.DEPTH(4), .WIDTH(32)) dut (
      .clk(clk), .n_rst(n_rst),
      .in_valid(in_valid), .in_result(in_result), .in_over_flow(in_over_flow), .in_ready(in_ready),
      .out_valid(out_valid), .out_result(out_result), .out_over_flow(out_over_flow), .out_ready(out_ready),
      .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .ovf_cnt(ovf_cnt), .level(level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_level"},     32'(level),         32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),      32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid),     32'd0);
      chk({tag, "_out_res"},   out_result,         32'd0);
      chk({tag, "_out_ovf"},   32'(out_over_flow), 32'd0);
      chk({tag, "_sticky"},    32'(sticky_ovf),    32'd0);
      chk({tag, "_cnt"},       32'(ovf_cnt),       32'd0);
   endtask

   initial begin
      n_rst = 1'b0; in_valid = 1'b0; in_result = '0; in_over_flow = 1'b0;
      out_ready = 1'b0; clr_sticky = 1'b0;
      #2;
      chk_reset_vals("por");
      @(negedge clk); n_rst = 1'b1;
      tick();

      // Some traffic, then reset asserted mid-cycle
      in_valid = 1'b1; in_result = 32'h0000_DEAD; in_over_flow = 1'b1;
      tick();
      in_valid = 1'b0; in_over_flow = 1'b0;
      chk("pre_rst_level", 32'(level), 32'd1);
      chk("pre_rst_sticky", 32'(sticky_ovf), 32'd1);
      #3 n_rst = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      tick();
      chk_reset_vals("held_rst");
      @(negedge clk); n_rst = 1'b1;
      tick();

      // Single entry, no bypass
      in_valid = 1'b1; in_result = 32'h0000_0005;
      chk("nobypass_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_res", out_result, 32'h0000_0005);
      chk("single_level", 32'(level), 32'd1);
      chk("single_ovf", 32'(out_over_flow), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("single_pop_valid", 32'(out_valid), 32'd0);
      chk("single_pop_res", out_result, 32'd0);
      chk("single_pop_level", 32'(level), 32'd0);

      // Fill to full, then offer one more that must be refused
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_result = 32'(i);
         chk("fill_in_ready", 32'(in_ready), 32'd1);
         tick();
         chk("fill_level", 32'(level), 32'(i));
      end
      chk("full_in_ready", 32'(in_ready), 32'd0);
      in_result = 32'h5;
      tick();
      tick();
      chk("full_hold_level", 32'(level), 32'd4);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_res", out_result, 32'(i));
         tick();
         chk("drain_level", 32'(level), 32'(4 - i));
      end
      chk("drain_empty", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Full-rate stream with pointer wrap
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_result = 32'hA0 + 32'(k);
         if (k > 0) begin
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_res", out_result, exp_q[0]);
         end
         tick();
         if (k > 0) void'(exp_q.pop_front());
         exp_q.push_back(32'hA0 + 32'(k));
         chk("stream_level", 32'(level), 32'd1);
      end
      in_valid = 1'b0;
      chk("stream_last_res", out_result, exp_q[0]);
      tick();
      void'(exp_q.pop_front());
      chk("stream_end_level", 32'(level), 32'd0);
      out_ready = 1'b0;

      // Overflow accounting
      chk("ovf_cnt_start", 32'(ovf_cnt), 32'd0);
      exp_q.push_back(32'h8000_0000);
      exp_q.push_back(32'h7FFF_FFFF);
      exp_q.push_back(32'h8000_0001);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_over_flow = 1'b1; in_result = exp_q[i];
         tick();
         chk("ovf_cnt_step", 32'(ovf_cnt), 32'(i + 1));
      end
      in_valid = 1'b0; in_over_flow = 1'b0;
      chk("ovf_sticky", 32'(sticky_ovf), 32'd1);
      chk("ovf_level", 32'(level), 32'd3);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("ovf_pop_ovf", 32'(out_over_flow), 32'd1);
         chk("ovf_pop_res", out_result, exp_q[0]);
         tick();
         void'(exp_q.pop_front());
      end
      out_ready = 1'b0;

      // Clear collides with an overflow push: set wins
      in_valid = 1'b1; in_over_flow = 1'b1; in_result = 32'h0000_1234; clr_sticky = 1'b1;
      tick();
      in_valid = 1'b0; in_over_flow = 1'b0;
      chk("coll_sticky", 32'(sticky_ovf), 32'd1);
      chk("coll_cnt", 32'(ovf_cnt), 32'd1);
      tick();
      chk("clr_sticky", 32'(sticky_ovf), 32'd0);
      chk("clr_cnt", 32'(ovf_cnt), 32'd0);
      chk("clr_iso_level", 32'(level), 32'd1);
      chk("clr_iso_res", out_result, 32'h0000_1234);
      clr_sticky = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("clr_iso_pop", 32'(level), 32'd0);

      // Counter saturation
      in_valid = 1'b1; in_over_flow = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_result = 32'(i);
         tick();
         if (i == 99)  chk("sat_cnt_100", 32'(ovf_cnt), 32'd100);
         if (i == 254) chk("sat_cnt_255", 32'(ovf_cnt), 32'd255);
      end
      in_valid = 1'b0; in_over_flow = 1'b0;
      chk("sat_cnt_300", 32'(ovf_cnt), 32'd255);
      chk("sat_level", 32'(level), 32'd1);
      tick();
      chk("sat_cnt_hold", 32'(ovf_cnt), 32'd255);
      chk("sat_sticky", 32'(sticky_ovf), 32'd1);
      chk("sat_drained", 32'(level), 32'd0);
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
